lab2_parity_serializer: RTL and testbench
=========================================

# lab2_parity_serializer

Serial transmitter with an appended parity bit: the transmit-side counterpart of the lab1 serial parity checker. It accepts a parallel word, then emits a one-cycle frame-start strobe, the word MSB-first one bit per clock, and a trailing parity bit. Its outputs drive a checker's `start`/`data_in` pair directly. A checker built with `DATA_WIDTH+1` must end every frame with `parity_error=0` when `EVEN_PARITY=1`.

## Interface
- `DATA_WIDTH`, 8: serialized word width; legal range 2..32.
- `EVEN_PARITY`, 1: 1 = parity bit makes the total count of ones (data plus parity) even; 0 = odd.
- `clk`  in  1: single clock; all logic is clocked on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: load request; sampled only when `ready=1`.
- `data`  in  DATA_WIDTH: word to send; captured on the accepting edge.
- `ready`  out  1: 1 in IDLE; combinational decode of state.
- `frame_start`  out  1: one-cycle strobe preceding the first data bit; connects to the checker's `start`.
- `data_out`  out  1: serial data and parity line; connects to the checker's `data_in`.
- `sending`  out  1: high during the DATA_WIDTH data-bit cycles.
- `parity_valid`  out  1: high during the parity-bit cycle.
- `busy`  out  1: high from the frame-start cycle through the parity cycle inclusive.

## Operation
- FSM states: IDLE, FRAME, DATA, PARITY.
- IDLE -> FRAME when `start=1`. On that edge, capture `data` into the shift register, clear the bit counter and clear the parity accumulator.
- FRAME -> DATA unconditionally after 1 cycle. `frame_start=1`, `data_out=0`.
- DATA lasts DATA_WIDTH cycles.
  - `data_out` = shift register MSB.
  - Each edge: shift the register left, XOR the outgoing bit into the accumulator, increment the counter.
  - Exit to PARITY when counter = DATA_WIDTH-1.
  - Counter width is `$clog2(DATA_WIDTH)`; the counter never wraps within a frame.
- PARITY lasts 1 cycle. `data_out` = accumulator XOR (`EVEN_PARITY` ? 0 : 1). Then go to IDLE.
- `start` is ignored outside IDLE. `data` is not resampled mid-frame, so a changing `data` does not corrupt the frame in progress.
- All outputs except `ready` are registered or decoded from state only. `data_out=0` in IDLE and FRAME.
- Reset values: state IDLE; `ready=1`; `frame_start=0`, `data_out=0`, `sending=0`, `parity_valid=0`, `busy=0`; counter, shift register and accumulator all 0.
- Reset mid-frame: the frame is abandoned at the next edge and all outputs take their reset values. No partial parity bit is emitted.
- Reset and `start` high together: reset wins and the start is dropped.

## Timing
- Edge N accepts `start`. Cycle N+1 is FRAME. Data bit k (k=0 is the MSB) appears in cycle N+2+k. Parity appears in cycle N+2+DATA_WIDTH. `ready=1` in cycle N+3+DATA_WIDTH.
- Frame length is DATA_WIDTH+2 cycles. Minimum start-to-start spacing is DATA_WIDTH+3 cycles.
- A `start` held high continuously produces back-to-back frames separated by exactly one IDLE cycle.
- The `frame_start`-then-bits ordering matches the checker, which begins counting on the edge after its `start`.

## Structure
- Package `lab2_parity_pkg` holds:
  - the `state_t` enum (IDLE, FRAME, DATA, PARITY);
  - the `EVEN`/`ODD` localparams;
  - a `parity_of(logic [31:0], int width)` function used by the bench model.
- Top module contains the FSM, counter and accumulator.
- Natural sub-module: `lab2_piso_shift`, a parallel-in/serial-out register with `load`, `shift` and `msb` ports, parameterized by DATA_WIDTH.
- Total RTL is roughly 150 lines.

## Test plan
- Send 8'hB5 with EVEN_PARITY=1.
  - Required: `frame_start` one cycle, then `data_out` 1,0,1,1,0,1,0,1, then parity 1; `sending` high exactly 8 cycles.
- Send 8'hCC.
  - Required: bits 1,1,0,0,1,1,0,0, then parity 0.
  - With EVEN_PARITY=0, the same word gives parity 1.
- Pulse `start` with 8'hFF, then pulse `start` with 8'h00 during the DATA state.
  - Required: the second start is ignored; bits are all 1 and parity is 0; `ready` returns 11 cycles after acceptance.
- Assert `reset` in the 4th data cycle of 8'hB5.
  - Required: the next cycle has all outputs at reset values, `ready=1` and no parity cycle.
  - A following send of 8'h01 produces a clean frame with parity 1.
- Loopback into a checker built with DATA_WIDTH=9, for 50 random words with `start` held high.
  - Required: `parity_error=0` after every parity bit.
  - Frames are exactly 1 IDLE cycle apart.

Source files
------------

// File: rtl/lab2_parity_pkg.sv
// Shared types and helpers for the parity serializer.
//   state_t    : serializer FSM states
//   EVEN / ODD : values for the EVEN_PARITY parameter
//   parity_of  : XOR reduction of the low `width` bits of a word
package lab2_parity_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FRAME  = 2'd1,
    DATA   = 2'd2,
    PARITY = 2'd3
  } state_t;

  localparam bit EVEN = 1'b1;
  localparam bit ODD  = 1'b0;

  // Returns 1 when the low `width` bits hold an odd number of ones.
  function automatic logic parity_of(logic [31:0] value, int width);
    logic p;
    p = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) p = p ^ value[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/lab2_piso_shift.sv
// Parallel-in / serial-out shift register, MSB first.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   load       : capture data (takes priority over shift)
//   shift      : shift left by one, zero fill
//   data       : parallel word to capture
//   msb        : current most significant bit
module lab2_piso_shift #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  msb
);

  logic [DATA_WIDTH-1:0] sreg;

  always_ff @(posedge clk) begin
    if (reset) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= data;
    end else if (shift) begin
      sreg <= {sreg[DATA_WIDTH-2:0], 1'b0};
    end
  end

  assign msb = sreg[DATA_WIDTH-1];

endmodule

// File: rtl/lab2_parity_serializer.sv
// Serial transmitter: frame-start strobe, data word MSB first, then parity.
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   start, data  : load request and word, accepted only while ready
//   ready        : idle, able to accept a word
//   frame_start  : one-cycle strobe ahead of the first data bit
//   data_out     : serial data followed by the parity bit
//   sending      : data-bit cycles
//   parity_valid : parity-bit cycle
//   busy         : frame-start cycle through parity cycle
module lab2_parity_serializer
  import lab2_parity_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter bit EVEN_PARITY = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  ready,
  output logic                  frame_start,
  output logic                  data_out,
  output logic                  sending,
  output logic                  parity_valid,
  output logic                  busy
);

  localparam int              CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  // Odd parity is the even-parity accumulator inverted.
  localparam logic            PAR_FLIP = (EVEN_PARITY == EVEN) ? 1'b0 : 1'b1;

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic             acc;
  logic             load;
  logic             shift;
  logic             msb;

  assign load  = (state == IDLE) && start;
  assign shift = (state == DATA);

  lab2_piso_shift #(.DATA_WIDTH(DATA_WIDTH)) u_piso (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .shift (shift),
    .data  (data),
    .msb   (msb)
  );

  // Strobes are registered alongside the state transition so they line up
  // with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      acc          <= 1'b0;
      frame_start  <= 1'b0;
      sending      <= 1'b0;
      parity_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state       <= FRAME;
            bit_cnt     <= '0;
            acc         <= 1'b0;
            frame_start <= 1'b1;
            busy        <= 1'b1;
          end
        end
        FRAME: begin
          state       <= DATA;
          frame_start <= 1'b0;
          sending     <= 1'b1;
        end
        DATA: begin
          acc <= acc ^ msb;
          if (bit_cnt == LAST_BIT) begin
            state        <= PARITY;
            sending      <= 1'b0;
            parity_valid <= 1'b1;
          end else begin
            // Held at the last index rather than wrapping.
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        PARITY: begin
          state        <= IDLE;
          parity_valid <= 1'b0;
          busy         <= 1'b0;
        end
        default: begin
          state        <= IDLE;
          frame_start  <= 1'b0;
          sending      <= 1'b0;
          parity_valid <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

  assign ready = (state == IDLE);

  always_comb begin
    data_out = 1'b0;
    if (state == DATA)        data_out = msb;
    else if (state == PARITY) data_out = acc ^ PAR_FLIP;
  end

endmodule

// File: tb/tb_lab2_parity_serializer.sv
// Scoreboard bench for lab2_parity_serializer: an even and an odd instance
// share all inputs; a monitor reassembles each frame and checks it against
// the queued expectation, and a 9-bit parity checker model listens to the
// even instance.
`timescale 1ns/1ps
module tb_lab2_parity_serializer;
  import lab2_parity_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] data;

  logic ready, frame_start, data_out, sending, parity_valid, busy;
  logic ready_o, frame_start_o, data_out_o, sending_o, parity_valid_o, busy_o;

  always #5 clk = ~clk;

  lab2_parity_serializer #(.DATA_WIDTH(W), .EVEN_PARITY(1'b1)) dut_e (
    .clk(clk), .reset(reset), .start(start), .data(data),
    .ready(ready), .frame_start(frame_start), .data_out(data_out),
    .sending(sending), .parity_valid(parity_valid), .busy(busy)
  );

  lab2_parity_serializer #(.DATA_WIDTH(W), .EVEN_PARITY(1'b0)) dut_o (
    .clk(clk), .reset(reset), .start(start), .data(data),
    .ready(ready_o), .frame_start(frame_start_o), .data_out(data_out_o),
    .sending(sending_o), .parity_valid(parity_valid_o), .busy(busy_o)
  );

  typedef struct {
    logic [W-1:0] word;
    logic         par;   // even-parity bit
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Checker built with DATA_WIDTH+1: starts counting on the edge after start.
  int   chk_cnt = W + 1;
  logic chk_acc = 1'b0;
  always @(posedge clk) begin
    if (reset) begin
      chk_cnt <= W + 1;
      chk_acc <= 1'b0;
    end else if (frame_start) begin
      chk_cnt <= 0;
      chk_acc <= 1'b0;
    end else if (chk_cnt < W + 1) begin
      chk_acc <= chk_acc ^ data_out;
      chk_cnt <= chk_cnt + 1;
    end
  end

  // Monitor
  logic [W-1:0] mon_bits, mon_bits_o;
  int   mon_n = 0;
  bit   fs_prev = 0;
  bit   par_prev = 0;
  bit   b2b = 0;
  int   b2b_n = 0;
  int   cyc = 0;
  int   last_par = 0;
  int   frames = 0;
  exp_t e;

  always @(negedge clk) begin
    cyc++;
    if (par_prev) begin
      check("checker_bit_count", chk_cnt, W + 1);
      check("checker_parity_error", {31'd0, chk_acc}, 0);
    end
    par_prev = 0;
    if (reset) begin
      mon_n   = 0;
      fs_prev = 0;
    end else begin
      if (frame_start) begin
        check("frame_data_out", {31'd0, data_out}, 0);
        if (b2b && b2b_n > 0) check("idle_gap", cyc - last_par, 2);
        mon_n      = 0;
        mon_bits   = '0;
        mon_bits_o = '0;
      end else if (sending) begin
        if (mon_n == 0) check("frame_then_bit", {31'd0, fs_prev}, 1);
        mon_bits   = {mon_bits[W-2:0], data_out};
        mon_bits_o = {mon_bits_o[W-2:0], data_out_o};
        mon_n++;
      end else if (parity_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_frame: got parity cycle, want none (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          check("sending_cycles", mon_n, W);
          check("data_bits", {24'd0, mon_bits}, {24'd0, e.word});
          check("data_bits_odd", {24'd0, mon_bits_o}, {24'd0, e.word});
          check("parity_even", {31'd0, data_out}, {31'd0, e.par});
          check("parity_odd", {31'd0, data_out_o}, {31'd0, ~e.par});
        end
        if (b2b) b2b_n++;
        last_par = cyc;
        par_prev = 1;
        frames++;
      end
      fs_prev = frame_start;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int limit);
    int k = 0;
    while (!ready && k < limit) begin
      tick();
      k++;
    end
    if (!ready) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_ready: ready=%0b after %0d cycles, want 1", ready, limit);
    end
  endtask

  task automatic send(input logic [W-1:0] w, input logic p);
    wait_ready(40);
    data  = w;
    start = 1'b1;
    tick();
    exp_q.push_back('{w, p});
    start = 1'b0;
    data  = ~w;   // must not leak into the frame in progress
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {31'd0, ready}, 1);
    check({tag, "_frame_start"}, {31'd0, frame_start}, 0);
    check({tag, "_data_out"}, {31'd0, data_out}, 0);
    check({tag, "_sending"}, {31'd0, sending}, 0);
    check({tag, "_parity_valid"}, {31'd0, parity_valid}, 0);
    check({tag, "_busy"}, {31'd0, busy}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int pv_cnt;
    int accepted;
    int guard;
    logic rdy;

    reset = 1'b1;
    start = 1'b0;
    data  = '0;
    tick(); tick(); tick();
    check_reset_outputs("reset");
    reset = 1'b0;
    tick();

    // Directed words: even parity computed by hand.
    send(8'hB5, 1'b1);
    send(8'hCC, 1'b0);

    // Start during DATA must be ignored; ready comes back 11 cycles after accept.
    wait_ready(40);
    data  = 8'hFF;
    start = 1'b1;
    tick();
    exp_q.push_back('{8'hFF, 1'b0});
    start = 1'b0;
    k = 1;
    tick(); tick(); tick();
    k += 3;
    data  = 8'h00;
    start = 1'b1;
    check("ready_in_data", {31'd0, ready}, 0);
    tick();
    k++;
    start = 1'b0;
    while (!ready && k < 30) begin
      tick();
      k++;
    end
    check("ready_latency", k, 11);

    // Reset in the 4th data cycle of 8'hB5.
    wait_ready(40);
    data  = 8'hB5;
    start = 1'b1;
    tick();
    exp_q.push_back('{8'hB5, 1'b1});
    start = 1'b0;
    tick(); tick(); tick(); tick();
    check("pre_reset_sending", {31'd0, sending}, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    check_reset_outputs("midframe");
    pv_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (parity_valid || busy) pv_cnt++;
      tick();
    end
    check("no_activity_after_reset", pv_cnt, 0);
    send(8'h01, 1'b1);

    // Reset and start together: reset wins.
    wait_ready(40);
    reset = 1'b1;
    start = 1'b1;
    data  = 8'h55;
    tick();
    reset = 1'b0;
    start = 1'b0;
    check("reset_start_ready", {31'd0, ready}, 1);
    tick();
    check("reset_start_dropped", {31'd0, busy}, 0);

    // Loopback with start held high.
    wait_ready(40);
    b2b      = 1;
    data     = W'($urandom);
    start    = 1'b1;
    accepted = 0;
    guard    = 0;
    while (accepted < 50 && guard < 50 * (W + 3) + 50) begin
      rdy = ready;
      tick();
      guard++;
      if (rdy) begin
        exp_q.push_back('{data, parity_of(32'(data), W)});
        accepted++;
        data = W'($urandom);
      end
    end
    start = 1'b0;
    check("loop_accepted", accepted, 50);

    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      tick();
      k++;
    end
    tick(); tick();
    check("queue_drained", exp_q.size(), 0);
    check("frames_seen", frames, 54);
    check("b2b_frames", b2b_n, 50);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
